// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
// Default widths, FSM state encoding and the bit-counter width.
package bin2bcd_seq_pkg;

   localparam int BIN_W_DEF  = 16;
   localparam int DIGITS_DEF = 5;
   localparam int CNT_W_DEF  = $clog2(BIN_W_DEF);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WORK = 1'b1
   } state_t;

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// One BCD nibble correction step of the shift-and-add-3 algorithm:
// any digit of 5 or more gets 3 added so the following left shift carries into the next digit.
module bcd_digit_adj (
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, with a start/busy/done handshake.
// The result register holds the previous value until the completion edge of the next conversion.
module bin2bcd_seq
   import bin2bcd_seq_pkg::*;
#(
   parameter int BIN_W  = BIN_W_DEF,
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [BIN_W-1:0]    bin_i,
   input  logic                start_i,
   output logic [4*DIGITS-1:0] bcd_bo,
   output logic                busy_o,
   output logic                done_o
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   state_t            state_reg;
   logic [SR_W-1:0]   sr_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [BCD_W-1:0]  bcd_reg;
   logic              busy_reg;
   logic              done_reg;

   logic [BCD_W-1:0]  adj_bcd;
   logic [SR_W-1:0]   adj_sr;
   logic [SR_W-1:0]   shift_next;

   // Per-digit add-3 correction on the BCD field, ahead of the shift.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit    (sr_reg[BIN_W + 4*gi +: 4]),
         .adjusted (adj_bcd[4*gi +: 4])
      );
   end

   assign adj_sr     = {adj_bcd, sr_reg[BIN_W-1:0]};
   assign shift_next = {adj_sr[SR_W-2:0], 1'b0};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= ST_IDLE;
         sr_reg    <= '0;
         cnt_reg   <= '0;
         bcd_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start_i) begin
                  sr_reg    <= {{BCD_W{1'b0}}, bin_i};
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= ST_WORK;
               end
            end
            ST_WORK: begin
               sr_reg  <= shift_next;
               cnt_reg <= cnt_reg + CNT_W'(1);
               // The last shift lands directly in the result register.
               if (cnt_reg == CNT_LAST) begin
                  bcd_reg   <= shift_next[SR_W-1 -: BCD_W];
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bcd_bo = bcd_reg;
   assign busy_o = busy_reg;
   assign done_o = done_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a cycle-level handshake model plus directed conversions.
// Expected digits come from decimal arithmetic, not from the shift-and-add-3 procedure.
module tb_bin2bcd_seq;

   localparam int BIN_W  = 16;
   localparam int DIGITS = 5;
   localparam int BCD_W  = 4 * DIGITS;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic [BIN_W-1:0]  bin_i = '0;
   logic              start_i = 1'b0;
   logic [BCD_W-1:0]  bcd_bo;
   logic              busy_o;
   logic              done_o;

   int checks   = 0;
   int failures = 0;

   bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .bin_i   (bin_i),
      .start_i (start_i),
      .bcd_bo  (bcd_bo),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [BCD_W-1:0] to_bcd(input int unsigned value);
      logic [BCD_W-1:0] r;
      int unsigned v;
      r = '0;
      v = value;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Handshake model: a countdown of remaining busy cycles and the captured value.
   bit               model_on = 1'b0;
   bit               m_busy = 1'b0;
   bit               m_done = 1'b0;
   logic [BCD_W-1:0] m_bcd = '0;
   int               m_left = 0;
   int unsigned      m_val = 0;

   always @(posedge clk_i) begin
      if (rst_i) begin
         model_on = 1'b1;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_bcd  = '0;
         m_left = 0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_bcd  = to_bcd(m_val);
            end
         end else if (start_i) begin
            m_val  = int'(bin_i);
            m_left = BIN_W;
            m_busy = 1'b1;
         end
      end
   end

   always @(negedge clk_i) begin
      if (model_on) begin
         check(busy_o == m_busy, "busy_cycle", 32'(busy_o), 32'(m_busy));
         check(done_o == m_done, "done_cycle", 32'(done_o), 32'(m_done));
         check(bcd_bo == m_bcd, "bcd_cycle", 32'(bcd_bo), 32'(m_bcd));
         if (done_o) begin
            for (int d = 0; d < DIGITS; d++) begin
               check(bcd_bo[4*d +: 4] <= 4'd9, "digit_le_9", 32'(bcd_bo[4*d +: 4]), 32'd9);
            end
         end
      end
   end

   task automatic start_conv(input logic [BIN_W-1:0] value);
      @(negedge clk_i);
      bin_i   = value;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   // Waits for done_o, optionally pulsing start_i with a new value at two WORK cycles.
   task automatic wait_done(input logic [BCD_W-1:0] exp, input string name,
                            input int p1, input int p2, input logic [BIN_W-1:0] noise);
      int busy_n;
      bit seen;
      busy_n = busy_o ? 1 : 0;
      seen = 1'b0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         if (i == p1 || i == p2) begin
            bin_i   = noise;
            start_i = 1'b1;
         end else begin
            start_i = 1'b0;
         end
         @(negedge clk_i);
         if (busy_o) busy_n++;
         if (done_o) seen = 1'b1;
      end
      start_i = 1'b0;
      check(seen, {name, "_done_seen"}, 32'(seen), 32'd1);
      check(busy_n == BIN_W, {name, "_busy_len"}, 32'(busy_n), 32'(BIN_W));
      check(bcd_bo == exp, {name, "_bcd"}, 32'(bcd_bo), 32'(exp));
      $display("conv %s: bcd=0x%05h busy_cycles=%0d", name, bcd_bo, busy_n);
   endtask

   initial begin
      int last_done;
      int n_done;
      int idle_n;

      // Pin the reference conversion with hand-computed values.
      check(to_bcd(400) == 20'h00400, "model_400", 32'(to_bcd(400)), 32'h00400);
      check(to_bcd(65535) == 20'h65535, "model_65535", 32'(to_bcd(65535)), 32'h65535);
      check(to_bcd(9999) == 20'h09999, "model_9999", 32'(to_bcd(9999)), 32'h09999);

      repeat (3) @(negedge clk_i);
      check(busy_o == 1'b0, "reset_busy", 32'(busy_o), 32'd0);
      check(done_o == 1'b0, "reset_done", 32'(done_o), 32'd0);
      check(bcd_bo == '0, "reset_bcd", 32'(bcd_bo), 32'd0);
      rst_i = 1'b0;

      start_conv(16'd400);
      wait_done(20'h00400, "v400", -1, -1, '0);
      start_conv(16'd0);
      wait_done(20'h00000, "v0", -1, -1, '0);
      start_conv(16'hFFFF);
      wait_done(20'h65535, "v65535", -1, -1, '0);

      // Restarts and input changes during WORK must not disturb the conversion.
      start_conv(16'd300);
      wait_done(20'h00300, "v300_noise", 2, 9, 16'd50);

      // start_i held high: a new accept one cycle after every completion.
      @(negedge clk_i);
      bin_i = 16'd9999;
      start_i = 1'b1;
      last_done = -1;
      n_done = 0;
      idle_n = 0;
      for (int c = 0; c < 80 && n_done < 3; c++) begin
         @(negedge clk_i);
         if (!busy_o && n_done > 0 && !done_o) idle_n++;
         if (done_o) begin
            check(bcd_bo == 20'h09999, "hold_bcd", 32'(bcd_bo), 32'h09999);
            if (last_done >= 0)
               check(c - last_done == BIN_W + 1, "hold_period", 32'(c - last_done), 32'(BIN_W + 1));
            last_done = c;
            n_done++;
         end
      end
      start_i = 1'b0;
      check(n_done == 3, "hold_count", 32'(n_done), 32'd3);
      check(idle_n == 0, "hold_no_idle", 32'(idle_n), 32'd0);
      $display("conv hold9999: done_pulses=%0d", n_done);
      repeat (2) @(negedge clk_i);

      // Reset in the middle of a conversion discards it.
      start_conv(16'd5);
      wait_done(20'h00005, "v5", -1, -1, '0);
      start_conv(16'd400);
      repeat (7) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check(busy_o == 1'b0, "midreset_busy", 32'(busy_o), 32'd0);
      check(bcd_bo == '0, "midreset_bcd", 32'(bcd_bo), 32'd0);
      n_done = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i);
         if (done_o) n_done++;
      end
      check(n_done == 0, "midreset_no_done", 32'(n_done), 32'd0);
      $display("conv midreset: bcd=0x%05h busy=%0b", bcd_bo, busy_o);
      start_conv(16'd8);
      wait_done(20'h00008, "v8", -1, -1, '0);

      // Results of the upstream unit for a=100,b=65 and a=1,b=126.
      start_conv(16'd400);
      wait_done(20'h00400, "chain400", -1, -1, '0);
      start_conv(16'd5);
      wait_done(20'h00005, "chain5", -1, -1, '0);

      repeat (2) @(negedge clk_i);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
